// File: rtl/wptr_full_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full_ctrl_if
// Description : Write-side bus bundle for wptr_full_ctrl. The walmost_full
//               member exists only when WPTR_ALMOST_FULL_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface wptr_full_ctrl_if #(
    parameter int ADDR_SIZE = 5
);
    logic                 winc;
    logic [ADDR_SIZE:0]   wq2_rptr;
    logic                 wfull;
    logic [ADDR_SIZE-1:0] waddr;
    logic [ADDR_SIZE:0]   wptr;
    logic [ADDR_SIZE:0]   wlevel;
    logic                 woverflow;
`ifdef WPTR_ALMOST_FULL_EN
    logic                 walmost_full;
`endif

    modport master (
        output winc,
        output wq2_rptr,
        input  wfull,
        input  waddr,
        input  wptr,
        input  wlevel,
`ifdef WPTR_ALMOST_FULL_EN
        input  walmost_full,
`endif
        input  woverflow
    );

    modport slave (
        input  winc,
        input  wq2_rptr,
        output wfull,
        output waddr,
        output wptr,
        output wlevel,
`ifdef WPTR_ALMOST_FULL_EN
        output walmost_full,
`endif
        output woverflow
    );
endinterface
`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full_ctrl
// Description : Async-FIFO write-side pointer, full flag, fill level and
//               sticky overflow. Define WPTR_ALMOST_FULL_EN to add walmost_full.
// Revision    : 1.0  initial release
// ============================================================================
module wptr_full_ctrl #(
    parameter int ADDR_SIZE = 5,
    parameter int AF_MARGIN = 4
) (
    input  wire logic         wclk,
    input  wire logic         wrst,
    wptr_full_ctrl_if.slave   bus
);
    localparam int C_PW = ADDR_SIZE + 1;

    logic [C_PW-1:0] wbin_q, wbin_d;
    logic [C_PW-1:0] wptr_q, wptr_d;
    logic [C_PW-1:0] wlevel_q, wlevel_d;
    logic            wfull_q, wfull_d;
    logic            woverflow_q, woverflow_d;

    logic            w_push;
    logic [C_PW-1:0] w_rbin;
    logic [C_PW-1:0] w_full_gray;

    assign w_push = bus.winc & ~wfull_q;

    // Binary bit i of a Gray code is the XOR of all Gray bits from i up to the MSB
    for (genvar i = 0; i < C_PW; i++) begin : g_g2b
        assign w_rbin[i] = ^(bus.wq2_rptr >> i);
    end

    assign w_full_gray = {~bus.wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], bus.wq2_rptr[ADDR_SIZE-2:0]};

    always_comb begin
        wbin_d      = wbin_q + {{ADDR_SIZE{1'b0}}, w_push};
        wptr_d      = (wbin_d >> 1) ^ wbin_d;
        wfull_d     = (wptr_d == w_full_gray);
        wlevel_d    = wbin_d - w_rbin;
        woverflow_d = woverflow_q | (bus.winc & wfull_q);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q      <= '0;
            wptr_q      <= '0;
            wfull_q     <= 1'b0;
            wlevel_q    <= '0;
            woverflow_q <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wptr_q      <= wptr_d;
            wfull_q     <= wfull_d;
            wlevel_q    <= wlevel_d;
            woverflow_q <= woverflow_d;
        end
    end

    assign bus.wfull     = wfull_q;
    assign bus.waddr     = wbin_q[ADDR_SIZE-1:0];
    assign bus.wptr      = wptr_q;
    assign bus.wlevel    = wlevel_q;
    assign bus.woverflow = woverflow_q;

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [C_PW-1:0] C_AF_THRESH = C_PW'((1 << ADDR_SIZE) - AF_MARGIN);

    logic walmost_full_q, walmost_full_d;

    assign walmost_full_d = (wlevel_d >= C_AF_THRESH);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            walmost_full_q <= 1'b0;
        end else begin
            walmost_full_q <= walmost_full_d;
        end
    end

    assign bus.walmost_full = walmost_full_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wptr_full_ctrl
// Description : Self-checking bench for wptr_full_ctrl (ADDR_SIZE=3).
// Revision    : 1.0  initial release
// ============================================================================
module tb_wptr_full_ctrl;
    localparam int ADDR_SIZE = 3;
    localparam int DEPTH     = 8;
    localparam int MOD       = 16;
    localparam int AF_MARGIN = 2;

    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    wptr_full_ctrl_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

    wptr_full_ctrl #(
        .ADDR_SIZE (ADDR_SIZE),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: write count mod 2*DEPTH and the registered outputs
    int         exp_wbin;
    logic [3:0] exp_wptr;
    logic [3:0] exp_level;
    logic       exp_full;
    logic       exp_ovf;
    logic       exp_af;
    logic       model_valid = 1'b0;

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    function automatic int g2b(input logic [3:0] g);
        for (int b = 0; b < MOD; b++) if (gray(b) == g) return b;
        return 0;
    endfunction

    function automatic int nxt(input int wb, input logic inc, input logic full);
        return (wb + ((inc && !full) ? 1 : 0)) % MOD;
    endfunction

    function automatic int fill(input int wb, input logic [3:0] g);
        return (wb - g2b(g) + MOD) % MOD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    always @(posedge wclk) begin
        model_valid <= 1'b1;
        if (wrst) begin
            exp_wbin  <= 0;
            exp_wptr  <= '0;
            exp_level <= '0;
            exp_full  <= 1'b0;
            exp_ovf   <= 1'b0;
            exp_af    <= 1'b0;
        end else begin
            exp_wbin  <= nxt(exp_wbin, bus.winc, exp_full);
            exp_wptr  <= gray(nxt(exp_wbin, bus.winc, exp_full));
            exp_level <= 4'(fill(nxt(exp_wbin, bus.winc, exp_full), bus.wq2_rptr));
            exp_full  <= (fill(nxt(exp_wbin, bus.winc, exp_full), bus.wq2_rptr) == DEPTH);
            exp_af    <= (fill(nxt(exp_wbin, bus.winc, exp_full), bus.wq2_rptr) >= DEPTH - AF_MARGIN);
            if (bus.winc && exp_full) exp_ovf <= 1'b1;
        end
    end

    always @(negedge wclk) begin
        if (model_valid) begin
            chk("m_wptr",  32'(bus.wptr),      32'(exp_wptr));
            chk("m_waddr", 32'(bus.waddr),     32'(exp_wbin % DEPTH));
            chk("m_wfull", 32'(bus.wfull),     32'(exp_full));
            chk("m_level", 32'(bus.wlevel),    32'(exp_level));
            chk("m_ovf",   32'(bus.woverflow), 32'(exp_ovf));
`ifdef WPTR_ALMOST_FULL_EN
            chk("m_af",    32'(bus.walmost_full), 32'(exp_af));
`endif
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [3:0] seq [8];
    int         rd;
    logic [3:0] s1;
    logic       was_rst;

    initial begin
        seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'b1100};
        wrst = 1'b1;
        bus.winc = 1'b1;
        bus.wq2_rptr = '0;
        repeat (2) @(negedge wclk);
        chk("rst_wptr",  32'(bus.wptr), 0);
        chk("rst_waddr", 32'(bus.waddr), 0);
        chk("rst_wfull", 32'(bus.wfull), 0);
        chk("rst_level", 32'(bus.wlevel), 0);
        chk("rst_ovf",   32'(bus.woverflow), 0);

        // Fill to full from empty
        wrst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge wclk);
            chk("fill_wptr", 32'(bus.wptr), 32'(seq[i]));
        end
        chk("full_flag",  32'(bus.wfull), 1);
        chk("full_level", 32'(bus.wlevel), 8);
        chk("full_waddr", 32'(bus.waddr), 0);

        // Writes while full are dropped and flagged
        repeat (3) begin
            @(negedge wclk);
            chk("ovf_wptr",  32'(bus.wptr), 32'hC);
            chk("ovf_level", 32'(bus.wlevel), 8);
        end
        chk("ovf_set", 32'(bus.woverflow), 1);
        bus.winc = 1'b0;
        @(negedge wclk);
        chk("ovf_sticky", 32'(bus.woverflow), 1);

        // Reader frees four entries
        bus.wq2_rptr = 4'b0110;
        @(negedge wclk);
        chk("drain_full",  32'(bus.wfull), 0);
        chk("drain_level", 32'(bus.wlevel), 4);
        chk("drain_waddr", 32'(bus.waddr), 0);
        bus.winc = 1'b1;
        @(negedge wclk);
        chk("drain_wptr",  32'(bus.wptr), 32'b1101);
        chk("drain_lvl5",  32'(bus.wlevel), 5);

        // Streaming with a two-cycle-late read pointer, across the wrap
        wrst = 1'b1;
        @(negedge wclk);
        wrst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            bus.wq2_rptr = gray((k >= 3) ? k - 3 : 0);
            bus.winc = 1'b1;
            @(negedge wclk);
            chk("stream_nofull", 32'(bus.wfull), 0);
            chk("stream_lvl_le3", 32'(bus.wlevel <= 4'd3), 1);
            if (k == 15) chk("wrap_1000", 32'(bus.wptr), 32'b1000);
            if (k == 16) chk("wrap_0000", 32'(bus.wptr), 0);
        end

`ifdef WPTR_ALMOST_FULL_EN
        wrst = 1'b1;
        @(negedge wclk);
        wrst = 1'b0;
        bus.wq2_rptr = '0;
        bus.winc = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge wclk);
            if (k == 5) chk("af_low", 32'(bus.walmost_full), 0);
            if (k == 6) begin
                chk("af_high",  32'(bus.walmost_full), 1);
                chk("af_level", 32'(bus.wlevel), 6);
            end
        end
        wrst = 1'b1;
        @(negedge wclk);
        chk("midrst_af",    32'(bus.walmost_full), 0);
        chk("midrst_wptr",  32'(bus.wptr), 0);
        chk("midrst_level", 32'(bus.wlevel), 0);
        chk("midrst_full",  32'(bus.wfull), 0);
        wrst = 1'b0;
`endif

        // Randomised traffic with a reader behind a two-stage synchroniser
        wrst = 1'b1;
        @(negedge wclk);
        wrst = 1'b0;
        rd = 0;
        s1 = '0;
        bus.wq2_rptr = '0;
        was_rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (was_rst) begin
                rd = 0;
                s1 = '0;
                bus.wq2_rptr = '0;
            end else begin
                if (((exp_wbin - (rd % MOD) + MOD) % MOD) > 0 && ($urandom % 10) < 4) rd++;
                bus.wq2_rptr = s1;
                s1 = gray(rd);
            end
            bus.winc = (($urandom % 10) < 7);
            wrst = (($urandom % 300) == 0);
            was_rst = wrst;
            @(negedge wclk);
        end

        wrst = 1'b0;
        bus.winc = 1'b0;
        @(negedge wclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
